// File: rtl/dma_request_unit.sv
// rtl/dma_request_unit.sv - N-channel DMA request merge, mask, arbitration and HRQ/HLDA/DACK handshake
module dma_request_unit #(
    parameter int                NUM_CH    = 4,
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] REQ_ADDR  = ADDR_W'(9),
    parameter logic [ADDR_W-1:0] MASK_ADDR = ADDR_W'(10),
    parameter int                ROTATE    = 0,
    parameter int                DREQ_HIGH = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IOR,
    input  logic              IOW,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataBus,
    output logic [DATA_W-1:0] ReadData,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] Auto_Initialization,
    input  logic              HLDA,
    input  logic              EOP,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, REQ_BUS, SERVICE} state_t;

    state_t            state;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   next_ptr;
    logic [CH_W-1:0]   winner;
    logic [CH_W-1:0]   wr_ch;
    logic              wr_ch_ok;
    logic [NUM_CH-1:0] soft_req;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] dreq_n;
    logic [NUM_CH-1:0] pending;
    logic              wr_en;
    logic              rd_en;
    logic              svc_eop;
    logic              unused_data;

    // Simultaneous strobes are treated as no access at all
    assign wr_en    = !IOW && IOR;
    assign rd_en    = !IOR && IOW;
    assign wr_ch    = DataBus[CH_W-1:0];
    assign wr_ch_ok = int'(wr_ch) < NUM_CH;
    assign dreq_n   = (DREQ_HIGH != 0) ? DREQ : ~DREQ;
    assign pending  = (soft_req | sync2) & ~mask;
    assign svc_eop  = (state == SERVICE) && EOP;
    assign next_ptr = (int'(ch) == NUM_CH - 1) ? '0 : ch + 1'b1;
    assign unused_data = &{1'b0, DataBus};

    // Pick the first pending channel scanning upward from the priority base, wrapping
    always_comb begin
        logic found;
        int   idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (ROTATE != 0) ? (int'(ptr) + k) % NUM_CH : k;
            if (!found && pending[idx]) begin
                winner = CH_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // Two-flop synchroniser on the polarity-normalised DREQ lines
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= dreq_n;
            sync2 <= sync1;
        end
    end

    // Request/mask registers; CPU writes come last so they win over terminal-count updates
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            soft_req <= '0;
            mask     <= '1;
        end else begin
            if (svc_eop) begin
                soft_req[ch] <= 1'b0;
                if (!Auto_Initialization[ch])
                    mask[ch] <= 1'b1;
            end
            if (wr_en && Address == REQ_ADDR && wr_ch_ok)
                soft_req[wr_ch] <= DataBus[CH_W];
            if (wr_en && Address == MASK_ADDR)
                mask <= DataBus[NUM_CH-1:0];
        end
    end

    // Status read returns the pending vector; other reads leave the register alone
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            ReadData <= '0;
        else if (rd_en && Address == REQ_ADDR)
            ReadData <= DATA_W'(pending);
    end

    // Bus handshake FSM; the winner is frozen once HRQ is raised
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            ch    <= '0;
            ptr   <= '0;
            HRQ   <= 1'b0;
            DACK  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        ch    <= winner;
                        HRQ   <= 1'b1;
                        state <= REQ_BUS;
                    end
                end
                REQ_BUS: begin
                    if (HLDA) begin
                        DACK  <= NUM_CH'(1) << ch;
                        state <= SERVICE;
                    end else if (!pending[ch]) begin
                        HRQ   <= 1'b0;
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (EOP || !pending[ch] || !HLDA) begin
                        HRQ   <= 1'b0;
                        DACK  <= '0;
                        state <= IDLE;
                        if (ROTATE != 0)
                            ptr <= next_ptr;
                    end
                end
                default: begin
                    HRQ   <= 1'b0;
                    DACK  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
